// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared types and helpers for the reverse AES-256 key schedule (AES_INV_KEY_EQUIV_EN adds InvMixColumns).
// Latency: combinational helpers only.
// Backpressure: not applicable.
package aes_inv_key_schedule_pkg;

  localparam int AES_KEY_LENGTH       = 256;
  localparam int AES_BLOCK_SIZE       = 128;
  localparam int AES_WORD_SIZE        = 32;
  localparam int AES_NUMBER_OF_ROUNDS = 14;
  localparam int RND_W                = 4;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(AES_NUMBER_OF_ROUNDS);

  typedef enum logic {
    INV_IDLE,
    INV_STREAM
  } inv_key_state_e;

  // Rcon for the even backward steps; index is round/2 (1..7).
  function automatic logic [AES_WORD_SIZE-1:0] rcon(input logic [2:0] idx);
    logic [7:0] rc;
    case (idx)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as x^254 in GF(2^8) followed by the affine map; 0 maps to 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_INV_KEY_EQUIV_EN
  function automatic logic [AES_WORD_SIZE-1:0] inv_mix_col(input logic [AES_WORD_SIZE-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [AES_BLOCK_SIZE-1:0] inv_mix_key(input logic [AES_BLOCK_SIZE-1:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction
`endif

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-256 expansion: (rk r-1, rk r, r) -> rk r-2.
// Latency: combinational. Backpressure: not applicable.
// Word ordering matches the forward expansion, word 1 in the top 32 bits.
module aes_inv_key_step
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [AES_BLOCK_SIZE-1:0] hi_i,
  input  logic [AES_WORD_SIZE-1:0]  lo_w4_i,
  input  logic [RND_W-1:0]          round_i,
  output logic [AES_BLOCK_SIZE-1:0] rk_o
);

  logic [AES_WORD_SIZE-1:0] h1, h2, h3, h4;
  logic [AES_WORD_SIZE-1:0] sub_in, sub_out, f_out;

  assign {h1, h2, h3, h4} = hi_i;

  // Even rounds use the RotWord+Rcon path; odd rounds only SubWord.
  assign sub_in = round_i[0] ? lo_w4_i : {lo_w4_i[23:0], lo_w4_i[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  assign f_out = round_i[0] ? sub_out : (sub_out ^ rcon(round_i[3:1]));
  assign rk_o  = {h1 ^ f_out, h2 ^ h1, h3 ^ h2, h4 ^ h3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte.
// Latency: combinational.
// Backpressure: not applicable.
module aes_sbox
  import aes_inv_key_schedule_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox(in_byte);

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Streams AES-256 round keys 14..0 from rk13/rk14; AES_INV_KEY_EQUIV_EN emits InvMixColumns keys for 1..13.
// Latency: first key valid one cycle after load, then one key per cycle.
// Backpressure: outputs hold while rk_ready is low; key_ready only in idle.
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [AES_KEY_LENGTH-1:0] key_in,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic [AES_BLOCK_SIZE-1:0] rk_data,
  output logic [RND_W-1:0]          rk_round,
  output logic                      rk_last
);

  inv_key_state_e              state_q, state_d;
  logic [AES_BLOCK_SIZE-1:0]   lo_q, lo_d;
  logic [AES_BLOCK_SIZE-1:0]   hi_q, hi_d;
  logic [RND_W-1:0]            round_q, round_d;
  logic [AES_BLOCK_SIZE-1:0]   step_rk;

  aes_inv_key_step u_step (
    .hi_i    (hi_q),
    .lo_w4_i (lo_q[AES_WORD_SIZE-1:0]),
    .round_i (round_q),
    .rk_o    (step_rk)
  );

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    round_d = round_q;
    case (state_q)
      INV_IDLE: begin
        if (key_valid) begin
          lo_d    = key_in[AES_KEY_LENGTH-1:AES_BLOCK_SIZE];
          hi_d    = key_in[AES_BLOCK_SIZE-1:0];
          round_d = LAST_RND;
          state_d = INV_STREAM;
        end
      end
      INV_STREAM: begin
        if (rk_ready) begin
          if (round_q == '0) begin
            state_d = INV_IDLE;
          end else begin
            // At round 1 the step result is never emitted, so lo is don't-care.
            hi_d    = lo_q;
            lo_d    = step_rk;
            round_d = round_q - 1'b1;
          end
        end
      end
      default: state_d = INV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INV_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      round_q <= round_d;
    end
  end

  assign key_ready = (state_q == INV_IDLE);
  assign rk_valid  = (state_q == INV_STREAM);
  assign rk_round  = round_q;
  assign rk_last   = rk_valid && (round_q == '0);

`ifdef AES_INV_KEY_EQUIV_EN
  assign rk_data = ((round_q != '0) && (round_q != LAST_RND)) ? inv_mix_key(hi_q) : hi_q;
`else
  assign rk_data = hi_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule against a forward-expansion reference.
// Covers FIPS-197 vectors, backpressure, held key_valid, and mid-stream reset.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   sb [256];
  logic [127:0] gold [15];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];

  typedef struct {
    logic [255:0] ck;
    int           stall;
  } vec_t;
  vec_t vecs [6];

  localparam logic [255:0] FIPS_CK  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_R13 = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
  localparam logic [127:0] FIPS_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] FIPS_R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_R0  = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_round  (rk_round),
    .rk_last   (rk_last)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa, bb;
    acc = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) acc ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // Reference S-box: brute-force multiplicative inverse, then bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, c, xb;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      xb  = 8'(x);
      for (int y = 1; y < 256; y++)
        if (gm(xb, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] o [4];
    logic [7:0] m [4];
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int k = 0; k < 4; k++) a[k] = c[31-8*k -: 8];
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int k = 0; k < 4; k++) o[r] ^= gm(a[k], m[(k - r + 4) % 4]);
    end
    return {o[0], o[1], o[2], o[3]};
  endfunction

  function automatic logic [127:0] out_exp(input logic [127:0] k, input int r);
`ifdef AES_INV_KEY_EQUIV_EN
    if (r >= 1 && r <= 13) return {imc(k[127:96]), imc(k[95:64]), imc(k[63:32]), imc(k[31:0])};
`endif
    return k;
  endfunction

  task automatic expand(input logic [255:0] ck);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = ck[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) gold[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int b = 0; b < 15; b++) exp_rk[b] = out_exp(gold[14-b], 14-b);
  endtask

  task automatic load(input logic [255:0] k);
    chk("load_idle_valid", rk_valid, 0);
    chk("load_key_ready", key_ready, 1);
    key_in = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("lat1_valid", rk_valid, 1);
    chk("lat1_round", rk_round, 14);
  endtask

  task automatic run_stream(input int stall, input bit hold, input logic [255:0] hold_key);
    for (int b = 0; b < 15; b++) begin
      int waits;
      bit done;
      waits = 0;
      done  = 1'b0;
      while (!done) begin
        chk("rk_valid", rk_valid, 1);
        chk("rk_data", rk_data, exp_rk[b]);
        chk("rk_round", rk_round, 128'(14 - b));
        chk("rk_last", rk_last, (b == 14));
        chk("stream_key_ready", key_ready, 0);
        got_rk[b] = rk_data;
        if (hold) begin
          key_valid = 1'b1;
          key_in    = hold_key;
        end
        rk_ready = (waits >= 8) || ($urandom_range(0, 99) >= stall);
        @(negedge clk);
        if (rk_ready) done = 1'b1;
        else waits++;
      end
    end
    rk_ready = 1'b0;
    chk("end_valid", rk_valid, 0);
    chk("end_key_ready", key_ready, 1);
    chk("end_last", rk_last, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] b_in;
    logic [255:0] rnd;
    build_sbox();
    for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
    vecs[0] = '{FIPS_CK, 0};
    vecs[1] = '{FIPS_CK, 50};
    vecs[2] = '{256'h0, 20};
    vecs[3] = '{{256{1'b1}}, 0};
    vecs[4] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 30};
    vecs[5] = '{rnd, 40};

    repeat (3) @(negedge clk);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_valid", rk_valid, 0);
    chk("rst_round", rk_round, 0);
    chk("rst_data", rk_data, 0);
    chk("rst_last", rk_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.3 round keys supplied literally.
    expand(FIPS_CK);
    load({FIPS_R13, FIPS_R14});
    run_stream(0, 1'b0, '0);
    chk("fips_rk14", got_rk[0], FIPS_R14);
    chk("fips_rk13", got_rk[1], out_exp(FIPS_R13, 13));
    chk("fips_rk1", got_rk[13], out_exp(FIPS_R1, 1));
    chk("fips_rk0", got_rk[14], FIPS_R0);

    for (int v = 0; v < 6; v++) begin
      expand(vecs[v].ck);
      load({gold[13], gold[14]});
      run_stream(vecs[v].stall, 1'b0, '0);
      chk("vec_rk1", got_rk[13], out_exp(vecs[v].ck[127:0], 1));
      chk("vec_rk0", got_rk[14], vecs[v].ck[255:128]);
    end

    // key_valid held through a stream: second key only taken after the rk0 beat.
    expand(vecs[5].ck);
    b_in = {gold[13], gold[14]};
    expand(vecs[4].ck);
    load({gold[13], gold[14]});
    run_stream(20, 1'b1, b_in);
    @(negedge clk);
    key_valid = 1'b0;
    chk("reload_valid", rk_valid, 1);
    chk("reload_round", rk_round, 14);
    expand(vecs[5].ck);
    run_stream(0, 1'b0, '0);

    // Asynchronous reset at round 7.
    expand(FIPS_CK);
    load({gold[13], gold[14]});
    rk_ready = 1'b1;
    repeat (7) @(negedge clk);
    chk("pre_rst_round", rk_round, 7);
    chk("pre_rst_data", rk_data, exp_rk[7]);
    rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", rk_valid, 0);
    chk("arst_key_ready", key_ready, 1);
    chk("arst_round", rk_round, 0);
    chk("arst_data", rk_data, 0);
    chk("arst_last", rk_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expand(vecs[3].ck);
    load({gold[13], gold[14]});
    run_stream(10, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
